// File: rtl/mcu_mem_pkg.sv
// Shared types and constants for the MCU data-RAM bus master.
package mcu_mem_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    RESP   = 3'd4
  } state_e;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 16;

  localparam int DEF_SETUP_CYC  = 1;
  localparam int DEF_STROBE_CYC = 1;
  localparam int DEF_HOLD_CYC   = 1;

  // Largest of the three phase lengths; sizes the shared phase counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ram_bus_master_if.sv
// Core request/response channel plus RAM pin bundle for ram_bus_master.
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
// rsp_valid is a one-cycle pulse with no backpressure, rsp_write/rsp_rdata qualified by it.
interface ram_bus_master_if
  import mcu_mem_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_q;
  logic              mem_cs;
  logic              mem_we;
  logic              mem_re;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, mem_q,
    output req_ready, rsp_valid, rsp_write, rsp_rdata,
    output mem_addr, mem_wdata, mem_cs, mem_we, mem_re
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, mem_q,
    input  req_ready, rsp_valid, rsp_write, rsp_rdata,
    input  mem_addr, mem_wdata, mem_cs, mem_we, mem_re
  );
endinterface

// File: rtl/ram_phase_timer.sv
// Load / count-down / done counter, reloaded at the start of each bus phase.
module ram_phase_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);
  logic [CNT_W-1:0] cnt_q;

  // Load N-1 on phase entry, then count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);
endmodule

// File: rtl/ram_bus_master.sv
// Turns single-beat core requests into SETUP -> STROBE -> HOLD cycles on the
// strobe-triggered data RAM and returns a one-cycle response pulse.
module ram_bus_master
  import mcu_mem_pkg::*;
#(
  parameter int ADDR_W     = RAM_ADDR_W,
  parameter int DATA_W     = RAM_DATA_W,
  parameter int SETUP_CYC  = DEF_SETUP_CYC,
  parameter int STROBE_CYC = DEF_STROBE_CYC,
  parameter int HOLD_CYC   = DEF_HOLD_CYC
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_bus_master_if.master  bus,
  output state_e            state_o
);
  localparam int CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC)) + 1;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  logic              rsp_write_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              cs_q;
  logic              we_q;
  logic              re_q;

  logic              load_d;
  logic [CNT_W-1:0]  load_val_d;
  logic              phase_done;

  ram_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (load_d),
    .load_val_i (load_val_d),
    .done_o     (phase_done)
  );

  // Reload the phase timer on entry to SETUP, STROBE and HOLD.
  always_comb begin
    load_d     = 1'b0;
    load_val_d = '0;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        load_d     = 1'b1;
        load_val_d = CNT_W'(SETUP_CYC - 1);
      end
      SETUP: if (phase_done) begin
        load_d     = 1'b1;
        load_val_d = CNT_W'(STROBE_CYC - 1);
      end
      STROBE: if (phase_done) begin
        load_d     = 1'b1;
        load_val_d = CNT_W'(HOLD_CYC - 1);
      end
      default: ;
    endcase
  end

  // Bus-cycle FSM; every output is set on the transition so it comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      write_q     <= 1'b0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      cs_q        <= 1'b0;
      we_q        <= 1'b0;
      re_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.req_valid) begin
          addr_q      <= bus.req_addr;
          wdata_q     <= bus.req_wdata;
          write_q     <= bus.req_write;
          req_ready_q <= 1'b0;
          cs_q        <= 1'b1;
          state_q     <= SETUP;
        end
        SETUP: if (phase_done) begin
          we_q    <= write_q;
          re_q    <= !write_q;
          state_q <= STROBE;
        end
        STROBE: if (phase_done) begin
          we_q <= 1'b0;
          re_q <= 1'b0;
          if (!write_q) rsp_rdata_q <= bus.mem_q;
          state_q <= HOLD;
        end
        HOLD: if (phase_done) begin
          cs_q        <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_write_q <= write_q;
          state_q     <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_cs    = cs_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_re    = re_q;
  assign state_o       = state_q;
endmodule

// File: tb/tb_ram_bus_master.sv
// Directed bench for ram_bus_master: default-timing DUT plus a 2/3/2 timing DUT,
// each with a behavioural strobe-triggered RAM.
module tb_ram_bus_master;
  import mcu_mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared request drive, steered by sel ----------------
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;

  ram_bus_master_if bus0();
  ram_bus_master_if bus1();
  state_e st0, st1;

  assign bus0.req_valid = req_valid && !sel;
  assign bus0.req_write = req_write;
  assign bus0.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus1.req_valid = req_valid && sel;
  assign bus1.req_write = req_write;
  assign bus1.req_addr  = req_addr;
  assign bus1.req_wdata = req_wdata;

  ram_bus_master dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.master), .state_o(st0));
  ram_bus_master #(.SETUP_CYC(2), .STROBE_CYC(3), .HOLD_CYC(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.master), .state_o(st1));

  // ---------------- behavioural RAMs ----------------
  logic [15:0] ram0 [256];
  logic [15:0] ram1 [256];
  logic [15:0] q0 = '0;
  logic [15:0] q1 = '0;
  assign bus0.mem_q = q0;
  assign bus1.mem_q = q1;

  always @(posedge bus0.mem_we) if (bus0.mem_cs) ram0[bus0.mem_addr] = bus0.mem_wdata;
  always @(posedge bus0.mem_re) if (bus0.mem_cs) q0 = ram0[bus0.mem_addr];
  always @(posedge bus1.mem_we) if (bus1.mem_cs) ram1[bus1.mem_addr] = bus1.mem_wdata;
  always @(posedge bus1.mem_re) if (bus1.mem_cs) q1 = ram1[bus1.mem_addr];

  // ---------------- selected-DUT view ----------------
  logic        m_ready, m_rsp_valid, m_rsp_write, m_cs, m_we, m_re;
  logic [15:0] m_rdata, m_wdata;
  logic [7:0]  m_addr;
  assign m_ready     = sel ? bus1.req_ready : bus0.req_ready;
  assign m_rsp_valid = sel ? bus1.rsp_valid : bus0.rsp_valid;
  assign m_rsp_write = sel ? bus1.rsp_write : bus0.rsp_write;
  assign m_rdata     = sel ? bus1.rsp_rdata : bus0.rsp_rdata;
  assign m_cs        = sel ? bus1.mem_cs    : bus0.mem_cs;
  assign m_we        = sel ? bus1.mem_we    : bus0.mem_we;
  assign m_re        = sel ? bus1.mem_re    : bus0.mem_re;
  assign m_addr      = sel ? bus1.mem_addr  : bus0.mem_addr;
  assign m_wdata     = sel ? bus1.mem_wdata : bus0.mem_wdata;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  int rsp_cnt = 0;
  logic [16:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every response pulse is matched against the next expected {write, rdata}.
  always @(negedge clk) begin
    if (rst_n && m_rsp_valid) begin
      rsp_cnt++;
      if (exp_q.size() == 0) check("rsp_unexpected", 32'd1, 32'd0);
      else check("rsp", {15'd0, m_rsp_write, m_rdata}, {15'd0, exp_q.pop_front()});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int g;
    g = 0;
    while (!m_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!m_ready) check("ready_timeout", 32'd0, 32'd1);
  endtask

  // One request; reports response cycle (accept edge T -> cycle T+lat),
  // strobe-high cycle counts, first strobe cycle and bus stability errors.
  task automatic send(input logic wr, input logic [7:0] a, input logic [15:0] d,
                      input logic [15:0] exp_rdata, output int lat, output int we_cyc,
                      output int re_cyc, output int first_strobe, output int bad);
    int n;
    lat = 0; we_cyc = 0; re_cyc = 0; first_strobe = 0; bad = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    exp_q.push_back({wr, exp_rdata});
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_write = ~wr; req_addr = ~a; req_wdata = ~d;
    n = 1;
    forever begin
      if (m_cs) begin
        if (m_addr != a) bad++;
        if (wr && m_wdata != d) bad++;
      end
      if ((m_we || m_re) && !m_cs) bad++;
      if (m_we && m_re) bad++;
      if (m_we) we_cyc++;
      if (m_re) re_cyc++;
      if ((m_we || m_re) && first_strobe == 0) first_strobe = n;
      if (m_rsp_valid) begin
        check("rsp_cs_low", {31'd0, m_cs}, 32'd0);
        break;
      end
      if (n >= 30) begin
        check("rsp_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
      n++;
    end
    lat = n;
  endtask

  // ---------------- directed sequence ----------------
  int lat, wec, rec, fst, bad, gap, c0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram0[i] = 16'h0000;
      ram1[i] = 16'h0000;
    end
    ram0[8'hFF] = 16'hC3C3;
    ram1[8'h55] = 16'hA5A5;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset and idle values
    check("rst_ready", {31'd0, bus0.req_ready}, 32'd1);
    check("rst_cs_we_re", {29'd0, bus0.mem_cs, bus0.mem_we, bus0.mem_re}, 32'd0);
    check("rst_rsp_valid", {31'd0, bus0.rsp_valid}, 32'd0);
    check("rst_rdata", {16'd0, bus0.rsp_rdata}, 32'd0);
    check("rst_state", {29'd0, st0}, {29'd0, IDLE});

    // Write 0x30 <- 0xBEEF
    send(1'b1, 8'h30, 16'hBEEF, 16'h0000, lat, wec, rec, fst, bad);
    check("wr_latency", lat, 4);
    check("wr_we_cycles", wec, 1);
    check("wr_re_cycles", rec, 0);
    check("wr_first_we", fst, 2);
    check("wr_bus_stable", bad, 0);
    check("wr_backdoor", {16'd0, ram0[8'h30]}, 32'h0000BEEF);

    // Read 0x30 back
    send(1'b0, 8'h30, 16'h5555, 16'hBEEF, lat, wec, rec, fst, bad);
    check("rd_latency", lat, 4);
    check("rd_re_cycles", rec, 1);
    check("rd_we_cycles", wec, 0);
    check("rd_bus_stable", bad, 0);

    // Back-to-back: valid held, write 0x00 <- 0x1234 then read 0xFF
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h00; req_wdata = 16'h1234;
    exp_q.push_back({1'b1, 16'hBEEF});
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    req_write = 1'b0; req_addr = 8'hFF; req_wdata = 16'h0000;
    exp_q.push_back({1'b0, 16'hC3C3});
    c0 = rsp_cnt;
    gap = 1;
    while (!m_ready && gap < 20) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_gap", gap, 5);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && rsp_cnt < c0 + 2; i++) @(negedge clk);
    check("b2b_rsp_count", rsp_cnt - c0, 2);
    check("b2b_backdoor", {16'd0, ram0[8'h00]}, 32'h00001234);

    // Read 0x00 back to confirm the back-to-back write
    send(1'b0, 8'h00, 16'h0000, 16'h1234, lat, wec, rec, fst, bad);
    check("rd0_latency", lat, 4);

    // Reset during STROBE of a write
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h40; req_wdata = 16'hDEAD;
    wait_ready();
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #2;
    check("pre_rst_we", {30'd0, bus0.mem_cs, bus0.mem_we}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("async_cs_we", {29'd0, bus0.mem_cs, bus0.mem_we, bus0.mem_re}, 32'd0);
    c0 = rsp_cnt;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("rst_no_rsp", rsp_cnt - c0, 0);
    check("rst_ready_after", {31'd0, bus0.req_ready}, 32'd1);
    check("rst_exp_empty", exp_q.size(), 0);

    // Long-timing DUT: SETUP=2, STROBE=3, HOLD=2
    sel = 1'b1;
    send(1'b0, 8'h55, 16'h0000, 16'hA5A5, lat, wec, rec, fst, bad);
    check("p_latency", lat, 8);
    check("p_re_cycles", rec, 3);
    check("p_first_re", fst, 3);
    check("p_bus_stable", bad, 0);
    send(1'b1, 8'hFF, 16'h0F0F, 16'hA5A5, lat, wec, rec, fst, bad);
    check("p_wr_latency", lat, 8);
    check("p_we_cycles", wec, 3);
    check("p_wr_backdoor", {16'd0, ram1[8'hFF]}, 32'h00000F0F);

    repeat (3) @(negedge clk);
    check("final_exp_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
